mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port (I) and data port (D).
- Sits between the riscvpipeline core and the memory.
- Sequences one memory transaction at a time with a req/ack handshake.
- Data requests have priority, with an anti-starvation guarantee for fetch and a watchdog for a memory that never acknowledges.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_WAIT, 4, consecutive lost arbitrations after which I wins the next arbitration.
- TIMEOUT, 64, cycles in a GRANT state without mem_ack before the transaction is aborted.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_req  input  1  fetch request; held with i_addr stable until i_ready.
- i_addr  input  AW  fetch address.
- i_rdata  output  DW  fetch data, valid when i_ready.
- i_ready  output  1  fetch transaction complete, single-cycle.
- d_req  input  1  data request; held with d_we/d_addr/d_wdata stable until d_ready.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  AW  data address.
- d_wdata  input  DW  store data.
- d_rdata  output  DW  load data, valid when d_ready.
- d_ready  output  1  data transaction complete, single-cycle.
- mem_req  output  1  transaction active toward memory.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wd  output  DW  memory write data.
- mem_rd  input  DW  memory read data, valid with mem_ack.
- mem_ack  input  1  memory completes the current transaction.
- err  output  1  sticky watchdog-timeout flag.
- stall_f  output  1  i_req & ~i_ready.
- stall_m  output  1  d_req & ~d_ready.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state = IDLE.
  - mem_req, mem_we, i_ready, d_ready, err all 0.
  - Wait and timeout counters = 0.
  - mem_addr, mem_wd, i_rdata, d_rdata = 0.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - Only d_req, or both requests with wait_cnt < MAX_WAIT: go to GRANT_D.
  - Only i_req, or both with wait_cnt >= MAX_WAIT: go to GRANT_I.
  - On entry to a GRANT state, the winner's addr, we and wdata are registered. Fetch always has we = 0.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) on each IDLE cycle where both requests are present and D wins.
  - Clears when GRANT_I is entered.
- GRANT_x:
  - mem_req = 1 and the registered fields drive the mem_* outputs.
  - When mem_ack = 1: x_ready = 1 combinationally in the same cycle, x_rdata = mem_rd (passthrough, no added latency), and the next state is IDLE.
  - Minimum latency: request seen in cycle N, mem_req in cycle N+1, ready in the first cycle with mem_ack (earliest N+1).
  - The requester samples ready at the same edge and may present its next request at once. That request is arbitrated in the following IDLE cycle, so there is one IDLE bubble between transactions.
- mem_ack while IDLE is ignored.
- A request dropped mid-grant does not abort the transaction; it completes and ready still pulses.
- Watchdog:
  - to_cnt counts cycles in a GRANT state and clears on entering IDLE.
  - When to_cnt reaches TIMEOUT-1 without mem_ack: pulse x_ready with x_rdata = 0, set err (sticky until reset), return to IDLE.
- i_ready and d_ready are never asserted in the same cycle.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - wait_cnt and MAX_WAIT are unused.
  - A 1-bit last_grant register (reset 0, meaning D) holds the port granted most recently.
  - On a simultaneous request, the port that was not last granted wins.
  - A lone request always wins.
- Undefined: data priority with the MAX_WAIT anti-starvation rule as above.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE = 2'd0, GRANT_I = 2'd1, GRANT_D = 2'd2).
  - Port-select constants (SEL_I, SEL_D).
  - Default TIMEOUT and MAX_WAIT values.
- One sub-module, mem_arb_pick: the combinational winner selection plus the wait_cnt/last_grant register. It isolates the policy that ARB_ROUND_ROBIN_EN swaps.

Test Plan:
- Lone fetch, i_addr = 0x100, mem_ack one cycle after mem_req with mem_rd = 0x00500113 -> mem_addr = 0x100, mem_we = 0, i_ready with i_rdata = 0x00500113, d_ready never asserted.
- Lone store, d_addr = 0x64, d_wdata = 0x7, we = 1 -> mem_we = 1, mem_wd = 0x7, d_ready on ack, stall_m high until then.
- Both requests held continuously, memory acks immediately, MAX_WAIT = 4 -> grant order D,D,D,D,I repeating. With ARB_ROUND_ROBIN_EN: D,I,D,I.
- Memory never acks, TIMEOUT = 64 -> ready pulses on the 64th GRANT cycle, rdata = 0, err = 1 and stays 1 until reset.
- Reset asserted asynchronously (between clock edges) during GRANT_D -> mem_req and d_ready drop to 0 immediately; after release, a pending i_req is granted from IDLE.
- mem_ack pulse while IDLE with no requests -> no ready pulse, state stays IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared state encoding, port-select constants and default limits for the
// instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arbState_t;

  // A grant select of 0 means the data port, matching the reset value of last-grant.
  localparam logic SEL_D = 1'b0;
  localparam logic SEL_I = 1'b1;

  localparam int DEF_TIMEOUT  = 64;
  localparam int DEF_MAX_WAIT = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port, memory bus and status signals of the arbiter.
// The arbiter uses the slave modport; the core/memory environment uses master.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic          mem_ack;

  logic          err;
  logic          stall_f;
  logic          stall_m;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd, mem_ack,
    output i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wd,
           err, stall_f, stall_m
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd, mem_ack,
    input  i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wd,
           err, stall_f, stall_m
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection for the arbiter: data priority with a lost-arbitration counter,
// or alternating grants when ARB_ROUND_ROBIN_EN is defined.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic reset,
  input  logic arbEn,
  input  logic iReq,
  input  logic dReq,
  output logic grantValid,
  output logic grantSel
);

  logic bothReq;
  assign bothReq = iReq & dReq;

`ifdef ARB_ROUND_ROBIN_EN

  logic lastGrantR;

  // Winner: on contention the port not granted last time, otherwise the lone requester.
  always_comb begin
    grantValid = 1'b0;
    grantSel   = SEL_D;
    if (arbEn && bothReq) begin
      grantValid = 1'b1;
      grantSel   = (lastGrantR == SEL_D) ? SEL_I : SEL_D;
    end else if (arbEn && iReq) begin
      grantValid = 1'b1;
      grantSel   = SEL_I;
    end else if (arbEn && dReq) begin
      grantValid = 1'b1;
      grantSel   = SEL_D;
    end else begin
      grantValid = 1'b0;
      grantSel   = SEL_D;
    end
  end

  // Remembers the most recently granted port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrantR <= SEL_D;
    end else if (grantValid) begin
      lastGrantR <= grantSel;
    end else begin
      lastGrantR <= lastGrantR;
    end
  end

`else

  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [WW-1:0] waitCntR;
  logic          starved;

  assign starved = (waitCntR >= WW'(MAX_WAIT));

  // Winner: data wins contention until fetch has lost MAX_WAIT times in a row.
  always_comb begin
    grantValid = 1'b0;
    grantSel   = SEL_D;
    if (arbEn && bothReq) begin
      grantValid = 1'b1;
      grantSel   = starved ? SEL_I : SEL_D;
    end else if (arbEn && iReq) begin
      grantValid = 1'b1;
      grantSel   = SEL_I;
    end else if (arbEn && dReq) begin
      grantValid = 1'b1;
      grantSel   = SEL_D;
    end else begin
      grantValid = 1'b0;
      grantSel   = SEL_D;
    end
  end

  // Counts fetch's consecutive losses; any fetch grant resets the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitCntR <= {WW{1'b0}};
    end else if (grantValid && (grantSel == SEL_I)) begin
      waitCntR <= {WW{1'b0}};
    end else if (grantValid && bothReq && !starved) begin
      waitCntR <= waitCntR + WW'(1);
    end else begin
      waitCntR <= waitCntR;
    end
  end

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (I) and data (D) ports, one
// transaction at a time, with a watchdog. Build option: ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  arbState_t     stateR;
  arbState_t     stateNext;
  logic [AW-1:0] addrR;
  logic          weR;
  logic [DW-1:0] wdataR;
  logic [TW-1:0] toCntR;
  logic          errR;

  logic arbEn;
  logic grantValid;
  logic grantSel;
  logic inGrant;
  logic timeoutHit;
  logic xferDone;
  logic iReadyS;
  logic dReadyS;

  assign arbEn      = (stateR == IDLE);
  assign inGrant    = (stateR == GRANT_I) || (stateR == GRANT_D);
  // An ack arriving in the final watchdog cycle still completes normally.
  assign timeoutHit = inGrant && !bus.mem_ack && (toCntR == TW'(TIMEOUT - 1));
  assign xferDone   = inGrant && (bus.mem_ack || timeoutHit);

  mem_arb_pick #(
    .MAX_WAIT(MAX_WAIT)
  ) uPick (
    .clk       (clk),
    .reset     (reset),
    .arbEn     (arbEn),
    .iReq      (bus.i_req),
    .dReq      (bus.d_req),
    .grantValid(grantValid),
    .grantSel  (grantSel)
  );

  // Next-state logic for the IDLE / GRANT_I / GRANT_D sequencer.
  always_comb begin
    stateNext = stateR;
    case (stateR)
      IDLE: begin
        if (grantValid) begin
          stateNext = (grantSel == SEL_I) ? GRANT_I : GRANT_D;
        end else begin
          stateNext = IDLE;
        end
      end
      GRANT_I, GRANT_D: begin
        if (xferDone) begin
          stateNext = IDLE;
        end else begin
          stateNext = stateR;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register, watchdog counter and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateR <= IDLE;
      toCntR <= {TW{1'b0}};
      errR   <= 1'b0;
    end else begin
      stateR <= stateNext;
      toCntR <= (inGrant && !xferDone) ? (toCntR + TW'(1)) : {TW{1'b0}};
      errR   <= errR | timeoutHit;
    end
  end

  // Captures the winner's request fields on entry to a grant state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrR  <= {AW{1'b0}};
      weR    <= 1'b0;
      wdataR <= {DW{1'b0}};
    end else if (arbEn && grantValid && (grantSel == SEL_I)) begin
      addrR  <= bus.i_addr;
      weR    <= 1'b0;
      wdataR <= {DW{1'b0}};
    end else if (arbEn && grantValid) begin
      addrR  <= bus.d_addr;
      weR    <= bus.d_we;
      wdataR <= bus.d_wdata;
    end else begin
      addrR  <= addrR;
      weR    <= weR;
      wdataR <= wdataR;
    end
  end

  assign iReadyS = (stateR == GRANT_I) && xferDone;
  assign dReadyS = (stateR == GRANT_D) && xferDone;

  assign bus.mem_req  = inGrant;
  assign bus.mem_we   = weR && inGrant;
  assign bus.mem_addr = addrR;
  assign bus.mem_wd   = wdataR;

  assign bus.i_ready  = iReadyS;
  assign bus.d_ready  = dReadyS;
  assign bus.i_rdata  = (iReadyS && bus.mem_ack) ? bus.mem_rd : {DW{1'b0}};
  assign bus.d_rdata  = (dReadyS && bus.mem_ack) ? bus.mem_rd : {DW{1'b0}};

  assign bus.err      = errR;
  assign bus.stall_f  = bus.i_req && !iReadyS;
  assign bus.stall_m  = bus.d_req && !dReadyS;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: lone ports, priority order,
// watchdog timeout, asynchronous reset mid-grant and ack while idle.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(
    .AW(32), .DW(32), .MAX_WAIT(4), .TIMEOUT(64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL sim_limit: time limit reached before summary");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    assertCount++;
    if ({bus.mem_req, bus.mem_we, bus.i_ready, bus.d_ready, bus.err} !== 5'b0) begin
      failCount++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {bus.mem_req, bus.mem_we, bus.i_ready, bus.d_ready, bus.err});
    end
    assertCount++;
    if (bus.mem_addr !== 32'h0) begin
      failCount++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr);
    end
    assertCount++;
    if (bus.mem_wd !== 32'h0) begin
      failCount++; $display("FAIL reset_wd: got %h want 0", bus.mem_wd);
    end
    assertCount++;
    if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin
      failCount++; $display("FAIL reset_rdata: got %h/%h want 0", bus.i_rdata, bus.d_rdata);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    assertCount++;
    if (bus.mem_req !== 1'b0) begin
      failCount++; $display("FAIL reset_idle: mem_req got %b want 0", bus.mem_req);
    end
  endtask

  task automatic test_lone_store();
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h64; bus.d_wdata = 32'h7;
    @(negedge clk);
    assertCount++;
    if ({bus.mem_req, bus.stall_m} !== 2'b01) begin
      failCount++; $display("FAIL store_wait: req/stall_m got %b want 01", {bus.mem_req, bus.stall_m});
    end
    tick();
    @(negedge clk);
    assertCount++;
    if ({bus.mem_req, bus.mem_we, bus.d_ready, bus.stall_m} !== 4'b1101) begin
      failCount++;
      $display("FAIL store_grant: req/we/rdy/stall got %b want 1101",
               {bus.mem_req, bus.mem_we, bus.d_ready, bus.stall_m});
    end
    assertCount++;
    if (bus.mem_addr !== 32'h64) begin
      failCount++; $display("FAIL store_addr: got %h want 00000064", bus.mem_addr);
    end
    assertCount++;
    if (bus.mem_wd !== 32'h7) begin
      failCount++; $display("FAIL store_wd: got %h want 00000007", bus.mem_wd);
    end
    tick();
    bus.mem_ack = 1'b1; bus.mem_rd = 32'hCAFE0000;
    @(negedge clk);
    assertCount++;
    if ({bus.d_ready, bus.i_ready, bus.stall_m} !== 3'b100) begin
      failCount++;
      $display("FAIL store_ack: d_rdy/i_rdy/stall got %b want 100", {bus.d_ready, bus.i_ready, bus.stall_m});
    end
    tick();
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    assertCount++;
    if ({bus.mem_req, bus.mem_we, bus.d_ready} !== 3'b000) begin
      failCount++;
      $display("FAIL store_done: req/we/rdy got %b want 000", {bus.mem_req, bus.mem_we, bus.d_ready});
    end
  endtask

  task automatic test_lone_fetch();
    tick();
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    tick();
    @(negedge clk);
    assertCount++;
    if ({bus.mem_req, bus.mem_we, bus.i_ready} !== 3'b100) begin
      failCount++;
      $display("FAIL fetch_grant: req/we/rdy got %b want 100", {bus.mem_req, bus.mem_we, bus.i_ready});
    end
    assertCount++;
    if (bus.mem_addr !== 32'h100) begin
      failCount++; $display("FAIL fetch_addr: got %h want 00000100", bus.mem_addr);
    end
    tick();
    bus.mem_ack = 1'b1; bus.mem_rd = 32'h00500113;
    @(negedge clk);
    assertCount++;
    if ({bus.i_ready, bus.d_ready} !== 2'b10) begin
      failCount++; $display("FAIL fetch_ack: i/d ready got %b want 10", {bus.i_ready, bus.d_ready});
    end
    assertCount++;
    if (bus.i_rdata !== 32'h00500113) begin
      failCount++; $display("FAIL fetch_rdata: got %h want 00500113", bus.i_rdata);
    end
    tick();
    bus.i_req = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    assertCount++;
    if ({bus.mem_req, bus.i_ready, bus.d_ready} !== 3'b000) begin
      failCount++;
      $display("FAIL fetch_done: req/i/d got %b want 000", {bus.mem_req, bus.i_ready, bus.d_ready});
    end
  endtask

  task automatic test_priority();
    logic [9:0] expI;
    int         g;
`ifdef ARB_ROUND_ROBIN_EN
    expI = 10'b1010101010;
`else
    expI = 10'b1000010000;
`endif
    g = 0;
    tick();
    bus.i_req = 1'b1; bus.i_addr = 32'h300;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
    bus.mem_ack = 1'b1; bus.mem_rd = 32'h000000AB;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      assertCount++;
      if (bus.i_ready & bus.d_ready) begin
        failCount++; $display("FAIL ready_exclusive: cycle %0d both ready high", k);
      end
      if (bus.i_ready | bus.d_ready) begin
        if (g < 10) begin
          assertCount++;
          if (bus.i_ready !== expI[g]) begin
            failCount++;
            $display("FAIL grant_order: grant %0d got %s want %s", g,
                     bus.i_ready ? "I" : "D", expI[g] ? "I" : "D");
          end
        end
        assertCount++;
        if ((bus.i_ready ? bus.i_rdata : bus.d_rdata) !== 32'h000000AB) begin
          failCount++;
          $display("FAIL grant_rdata: grant %0d got %h want 000000ab", g,
                   bus.i_ready ? bus.i_rdata : bus.d_rdata);
        end
        g++;
      end
    end
    assertCount++;
    if (g !== 10) begin
      failCount++; $display("FAIL grant_count: got %0d want 10", g);
    end
    tick();
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int          grantCycles;
    int          readyAt;
    logic [31:0] rdataAt;
    logic        errAt;
    grantCycles = 0; readyAt = 0; rdataAt = 32'hFFFFFFFF; errAt = 1'b1;
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
    bus.mem_ack = 1'b0; bus.mem_rd = 32'hDEADBEEF;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.mem_req) grantCycles++;
      if (bus.d_ready) begin
        readyAt = grantCycles; rdataAt = bus.d_rdata; errAt = bus.err;
        break;
      end
    end
    assertCount++;
    if (readyAt !== 64) begin
      failCount++; $display("FAIL timeout_cycle: ready on grant cycle %0d want 64", readyAt);
    end
    assertCount++;
    if (rdataAt !== 32'h0) begin
      failCount++; $display("FAIL timeout_rdata: got %h want 0", rdataAt);
    end
    assertCount++;
    if (errAt !== 1'b0) begin
      failCount++; $display("FAIL timeout_err_early: err got %b want 0 during pulse", errAt);
    end
    tick();
    bus.d_req = 1'b0;
    @(negedge clk);
    assertCount++;
    if ({bus.err, bus.mem_req} !== 2'b10) begin
      failCount++; $display("FAIL timeout_err: err/req got %b want 10", {bus.err, bus.mem_req});
    end
    tick();
    bus.i_req = 1'b1; bus.i_addr = 32'h104;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rd = 32'h00000013;
    @(negedge clk);
    assertCount++;
    if ({bus.i_ready, bus.err} !== 2'b11) begin
      failCount++; $display("FAIL err_sticky_ack: rdy/err got %b want 11", {bus.i_ready, bus.err});
    end
    tick();
    bus.i_req = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    assertCount++;
    if (bus.err !== 1'b1) begin
      failCount++; $display("FAIL err_sticky: got %b want 1", bus.err);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 32'h55;
    bus.i_req = 1'b1; bus.i_addr = 32'h120;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rd = 32'h00001234;
    #1;
    assertCount++;
    if ({bus.mem_req, bus.d_ready, bus.mem_we} !== 3'b111) begin
      failCount++;
      $display("FAIL rst_pre: req/d_rdy/we got %b want 111", {bus.mem_req, bus.d_ready, bus.mem_we});
    end
    #1;
    reset = 1'b1;
    #1;
    assertCount++;
    if ({bus.mem_req, bus.d_ready, bus.i_ready, bus.mem_we, bus.err} !== 5'b00000) begin
      failCount++;
      $display("FAIL rst_async: req/d/i/we/err got %b want 00000",
               {bus.mem_req, bus.d_ready, bus.i_ready, bus.mem_we, bus.err});
    end
    assertCount++;
    if (bus.mem_addr !== 32'h0) begin
      failCount++; $display("FAIL rst_async_addr: got %h want 0", bus.mem_addr);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    assertCount++;
    if ({bus.mem_req, bus.mem_we} !== 2'b10) begin
      failCount++; $display("FAIL rst_regrant: req/we got %b want 10", {bus.mem_req, bus.mem_we});
    end
    assertCount++;
    if (bus.mem_addr !== 32'h120) begin
      failCount++; $display("FAIL rst_regrant_addr: got %h want 00000120", bus.mem_addr);
    end
    tick();
    bus.mem_ack = 1'b1; bus.mem_rd = 32'h00000077;
    @(negedge clk);
    assertCount++;
    if ({bus.i_ready, bus.d_ready, bus.i_rdata} !== {2'b10, 32'h00000077}) begin
      failCount++;
      $display("FAIL rst_regrant_ack: i/d ready %b%b rdata %h want 10 00000077",
               bus.i_ready, bus.d_ready, bus.i_rdata);
    end
    tick();
    bus.i_req = 1'b0; bus.mem_ack = 1'b0;
  endtask

  task automatic test_idle_ack();
    tick();
    bus.mem_ack = 1'b1; bus.mem_rd = 32'h00000099;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      assertCount++;
      if ({bus.mem_req, bus.i_ready, bus.d_ready} !== 3'b000) begin
        failCount++;
        $display("FAIL idle_ack: cycle %0d req/i/d got %b want 000", k,
                 {bus.mem_req, bus.i_ready, bus.d_ready});
      end
    end
    tick();
    bus.mem_ack = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    @(negedge clk);
    assertCount++;
    if (bus.mem_req !== 1'b0) begin
      failCount++; $display("FAIL idle_after_ack: req got %b want 0", bus.mem_req);
    end
    tick();
    @(negedge clk);
    assertCount++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h10}) begin
      failCount++;
      $display("FAIL idle_then_grant: req %b addr %h want 1 00000010", bus.mem_req, bus.mem_addr);
    end
    tick();
    bus.mem_ack = 1'b1; bus.mem_rd = 32'h0000ABCD;
    @(negedge clk);
    assertCount++;
    if ({bus.d_ready, bus.d_rdata} !== {1'b1, 32'h0000ABCD}) begin
      failCount++;
      $display("FAIL idle_then_load: rdy %b rdata %h want 1 0000abcd", bus.d_ready, bus.d_rdata);
    end
    tick();
    bus.d_req = 1'b0; bus.mem_ack = 1'b0;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    bus.i_req   = 1'b0; bus.i_addr  = 32'h0;
    bus.d_req   = 1'b0; bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0; bus.d_wdata = 32'h0;
    bus.mem_rd  = 32'h0; bus.mem_ack = 1'b0;
    test_reset();
    test_lone_store();
    test_lone_fetch();
    test_priority();
    test_timeout();
    test_reset_mid();
    test_idle_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
